// File: rtl/chip_dac_pkg.sv
// Shared frame geometry and decoder state type for the chip DAC programming interface.
package chip_dac_pkg;

    localparam int unsigned ADDR_W     = 3;
    localparam int unsigned LVL_W      = 8;
    localparam int unsigned NUM_DAC    = 2 ** ADDR_W;
    localparam int unsigned FRAME_BITS = 1 + ADDR_W + LVL_W;

    typedef enum logic [1:0] {
        StIdle,
        StAddr,
        StLevel
    } state_e;

endpackage

// File: rtl/chip_sig_sync.sv
// Synchronises chip_rst / chip_clk / chip_data_in into the clk domain and flags chip_clk falls.
module chip_sig_sync
    import chip_dac_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic chip_rst,
    input  logic chip_clk,
    input  logic chip_data_in,
    output logic rst_sync,
    output logic data_sync,
    output logic clk_fall
);

    logic [SYNC_STAGES-1:0] rst_q;
    logic [SYNC_STAGES-1:0] clk_q;
    logic [SYNC_STAGES-1:0] dat_q;
    logic                   clk_prev_q;

    // chip_clk chain and its edge flop reset low so leaving rst never fakes a fall.
    always_ff @(posedge clk) begin
        if (rst) begin
            rst_q      <= '0;
            clk_q      <= '0;
            dat_q      <= '1;
            clk_prev_q <= 1'b0;
        end else begin
            rst_q      <= {rst_q[SYNC_STAGES-2:0], chip_rst};
            clk_q      <= {clk_q[SYNC_STAGES-2:0], chip_clk};
            dat_q      <= {dat_q[SYNC_STAGES-2:0], chip_data_in};
            clk_prev_q <= clk_q[SYNC_STAGES-1];
        end
    end

    assign rst_sync  = rst_q[SYNC_STAGES-1];
    assign data_sync = dat_q[SYNC_STAGES-1];
    assign clk_fall  = clk_prev_q & ~clk_q[SYNC_STAGES-1];

endmodule

// File: rtl/chip_serial_decoder.sv
// Receive-side decoder for the chip DAC serial link: start bit, LSB-first address and level,
// updating an 8-entry DAC register image and reporting completed and aborted frames.
module chip_serial_decoder
    import chip_dac_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned NUM_DAC     = chip_dac_pkg::NUM_DAC,
    parameter int unsigned ADDR_W      = chip_dac_pkg::ADDR_W,
    parameter int unsigned LVL_W       = chip_dac_pkg::LVL_W,
    parameter int unsigned CNT_W       = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     chip_rst,
    input  logic                     chip_clk,
    input  logic                     chip_data_in,
    output logic [NUM_DAC*LVL_W-1:0] dac_regs,
    output logic                     frame_valid,
    output logic [ADDR_W-1:0]        frame_addr,
    output logic [LVL_W-1:0]         frame_level,
    output logic [CNT_W-1:0]         frame_count,
    output logic                     frame_abort
);

    localparam int unsigned AIdxW   = $clog2(ADDR_W);
    localparam int unsigned LIdxW   = $clog2(LVL_W);
    localparam int unsigned CntBits = (LIdxW > AIdxW) ? LIdxW : AIdxW;

    logic rst_sync;
    logic data_sync;
    logic clk_fall;

    chip_sig_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk          (clk),
        .rst          (rst),
        .chip_rst     (chip_rst),
        .chip_clk     (chip_clk),
        .chip_data_in (chip_data_in),
        .rst_sync     (rst_sync),
        .data_sync    (data_sync),
        .clk_fall     (clk_fall)
    );

    state_e                            state_q;
    logic [CntBits-1:0]                cnt_q;
    logic [ADDR_W-1:0]                 addr_q;
    logic [LVL_W-1:0]                  level_q;
    logic [LVL_W-1:0]                  level_full;
    logic [NUM_DAC-1:0][LVL_W-1:0]     dac_q;

    // Level including the bit being sampled now, so the final bit commits in the same cycle.
    always_comb begin
        level_full                       = level_q;
        level_full[cnt_q[LIdxW-1:0]]     = data_sync;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            addr_q      <= '0;
            level_q     <= '0;
            dac_q       <= '0;
            frame_valid <= 1'b0;
            frame_abort <= 1'b0;
            frame_addr  <= '0;
            frame_level <= '0;
            frame_count <= '0;
        end else begin
            frame_valid <= 1'b0;
            frame_abort <= 1'b0;
            if (!rst_sync) begin
                // Chip reset beats any coincident fall; frame stats are kept for the host.
                dac_q   <= '0;
                state_q <= StIdle;
                cnt_q   <= '0;
                if (state_q != StIdle) frame_abort <= 1'b1;
            end else if (clk_fall) begin
                unique case (state_q)
                    StIdle: begin
                        if (!data_sync) begin
                            state_q <= StAddr;
                            cnt_q   <= '0;
                        end
                    end
                    StAddr: begin
                        addr_q[cnt_q[AIdxW-1:0]] <= data_sync;
                        if (cnt_q == CntBits'(ADDR_W - 1)) begin
                            state_q <= StLevel;
                            cnt_q   <= '0;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    StLevel: begin
                        level_q <= level_full;
                        if (cnt_q == CntBits'(LVL_W - 1)) begin
                            dac_q[addr_q] <= level_full;
                            frame_addr    <= addr_q;
                            frame_level   <= level_full;
                            frame_valid   <= 1'b1;
                            if (frame_count != {CNT_W{1'b1}}) frame_count <= frame_count + 1'b1;
                            state_q       <= StIdle;
                            cnt_q         <= '0;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    default: begin
                        state_q <= StIdle;
                        cnt_q   <= '0;
                    end
                endcase
            end
        end
    end

    assign dac_regs = dac_q;

endmodule

// File: tb/tb_chip_serial_decoder.sv
// Directed bench: drives the chip serial link like the transmitter and checks decoded frames.
module tb_chip_serial_decoder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        chip_rst = 1'b0;
    logic        chip_clk = 1'b0;
    logic        chip_data_in = 1'b1;

    logic [63:0] dac_regs;
    logic        frame_valid;
    logic [2:0]  frame_addr;
    logic [7:0]  frame_level;
    logic [15:0] frame_count;
    logic        frame_abort;

    logic [63:0] s_dac_regs;
    logic        s_frame_valid;
    logic [2:0]  s_frame_addr;
    logic [7:0]  s_frame_level;
    logic [1:0]  s_frame_count;
    logic        s_frame_abort;

    int vectors = 0;
    int miscompares = 0;
    int n_valid = 0;
    int n_abort = 0;
    int s_valid = 0;
    int mark_v, mark_a, mark_s;

    always #5 clk = ~clk;

    chip_serial_decoder dut (
        .clk          (clk),
        .rst          (rst),
        .chip_rst     (chip_rst),
        .chip_clk     (chip_clk),
        .chip_data_in (chip_data_in),
        .dac_regs     (dac_regs),
        .frame_valid  (frame_valid),
        .frame_addr   (frame_addr),
        .frame_level  (frame_level),
        .frame_count  (frame_count),
        .frame_abort  (frame_abort)
    );

    chip_serial_decoder #(
        .CNT_W (2)
    ) dut_sat (
        .clk          (clk),
        .rst          (rst),
        .chip_rst     (chip_rst),
        .chip_clk     (chip_clk),
        .chip_data_in (chip_data_in),
        .dac_regs     (s_dac_regs),
        .frame_valid  (s_frame_valid),
        .frame_addr   (s_frame_addr),
        .frame_level  (s_frame_level),
        .frame_count  (s_frame_count),
        .frame_abort  (s_frame_abort)
    );

    always @(negedge clk) begin
        if (frame_valid)   n_valid++;
        if (frame_abort)   n_abort++;
        if (s_frame_valid) s_valid++;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_rst();
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    // Data changes just after chip_clk rises; half-period of 8 clk cycles.
    task automatic send_bit(input logic b);
        @(negedge clk);
        chip_clk = 1'b1;
        @(negedge clk);
        chip_data_in = b;
        repeat (7) @(negedge clk);
        chip_clk = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic send_frame(input logic [2:0] a, input logic [7:0] l);
        send_bit(1'b0);
        for (int i = 0; i < 3; i++) send_bit(a[i]);
        for (int i = 0; i < 8; i++) send_bit(l[i]);
    endtask

    initial begin
        // Reset state
        do_rst();
        check("rst_dac", dac_regs, 64'h0);
        check("rst_valid", {63'h0, frame_valid}, 64'h0);
        check("rst_abort", {63'h0, frame_abort}, 64'h0);
        check("rst_addr", {61'h0, frame_addr}, 64'h0);
        check("rst_level", {56'h0, frame_level}, 64'h0);
        check("rst_count", {48'h0, frame_count}, 64'h0);

        // Single frame after chip reset preamble
        mark_v = n_valid; mark_a = n_abort;
        for (int i = 0; i < 3; i++) send_bit(1'b1);
        chip_rst = 1'b1;
        send_bit(1'b1);
        send_frame(3'd5, 8'hA5);
        check("f1_pulses", 64'(n_valid - mark_v), 64'd1);
        check("f1_addr", {61'h0, frame_addr}, 64'd5);
        check("f1_level", {56'h0, frame_level}, 64'hA5);
        check("f1_dac", dac_regs, 64'hA5 << 40);
        check("f1_count", {48'h0, frame_count}, 64'd1);
        check("f1_noabort", 64'(n_abort - mark_a), 64'd0);

        // Back-to-back repeated frames
        do_rst();
        mark_v = n_valid;
        for (int i = 0; i < 4; i++) send_frame(3'd2, 8'h3C);
        check("rep_pulses", 64'(n_valid - mark_v), 64'd4);
        check("rep_dac", dac_regs, 64'h3C << 16);
        check("rep_count", {48'h0, frame_count}, 64'd4);

        // Overwrite, last value wins
        do_rst();
        send_frame(3'd0, 8'h01);
        send_frame(3'd7, 8'hFF);
        send_frame(3'd0, 8'h80);
        check("ow_dac", dac_regs, 64'hFF00_0000_0000_0080);
        check("ow_count", {48'h0, frame_count}, 64'd3);
        check("ow_addr", {61'h0, frame_addr}, 64'd0);

        // Abort after 5 payload bits
        mark_v = n_valid; mark_a = n_abort;
        send_bit(1'b0);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b0);
        send_bit(1'b1); send_bit(1'b1);
        chip_rst = 1'b0;
        send_bit(1'b1);
        send_bit(1'b0);
        check("ab_pulses", 64'(n_abort - mark_a), 64'd1);
        check("ab_novalid", 64'(n_valid - mark_v), 64'd0);
        check("ab_dac", dac_regs, 64'h0);
        check("ab_count", {48'h0, frame_count}, 64'd3);
        check("ab_level", {56'h0, frame_level}, 64'h80);
        chip_rst = 1'b1;
        send_bit(1'b1);
        send_frame(3'd1, 8'h55);
        check("ab_next_dac", dac_regs, 64'h55 << 8);
        check("ab_next_addr", {61'h0, frame_addr}, 64'd1);
        check("ab_next_count", {48'h0, frame_count}, 64'd4);
        check("ab_once", 64'(n_abort - mark_a), 64'd1);

        // Idle line
        mark_v = n_valid; mark_a = n_abort;
        for (int i = 0; i < 50; i++) send_bit(1'b1);
        check("idle_novalid", 64'(n_valid - mark_v), 64'd0);
        check("idle_noabort", 64'(n_abort - mark_a), 64'd0);
        check("idle_count", {48'h0, frame_count}, 64'd4);
        send_frame(3'd6, 8'h99);
        check("idle_then_dac", dac_regs, (64'h99 << 48) | (64'h55 << 8));

        // Saturation on the 2-bit counter instance
        do_rst();
        send_frame(3'd3, 8'h11);
        send_frame(3'd4, 8'h22);
        check("sat_pre", {62'h0, s_frame_count}, 64'd2);
        mark_s = s_valid;
        send_frame(3'd1, 8'hAA);
        send_frame(3'd1, 8'hBB);
        send_frame(3'd1, 8'hCC);
        check("sat_pulses", 64'(s_valid - mark_s), 64'd3);
        check("sat_count", {62'h0, s_frame_count}, 64'd3);
        check("sat_level", {56'h0, s_frame_level}, 64'hCC);
        check("sat_dac", s_dac_regs, (64'h22 << 32) | (64'h11 << 24) | (64'hCC << 8));
        check("wide_count", {48'h0, frame_count}, 64'd5);

        // rst mid-frame: no abort, partial frame discarded
        mark_a = n_abort; mark_v = n_valid;
        send_bit(1'b0);
        send_bit(1'b1); send_bit(1'b1);
        do_rst();
        for (int i = 0; i < 9; i++) send_bit(1'b1);
        check("rstmid_noabort", 64'(n_abort - mark_a), 64'd0);
        check("rstmid_novalid", 64'(n_valid - mark_v), 64'd0);
        check("rstmid_count", {48'h0, frame_count}, 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #20ms;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end

endmodule
